ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS32 core.
- Each cycle it captures EX results: GPR write address/enable/data and HI/LO write. It presents them to the MEM stage.
- Holds the 2-cycle madd/msub accumulator (partial product plus cycle counter) and feeds it back to EX while the pipeline is stalled.
- Implements ctrl-driven stall, bubble insertion and flush.

Parameters:
DATA_W, 32, GPR/HI/LO data width
ADDR_W, 5, GPR address width
NOP_ADDR, 0, GPR address driven when the stage carries a bubble

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
stall  in  6  ctrl stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
flush  in  1  exception/pipeline flush from ctrl
ex_wd_addr  in  ADDR_W  destination GPR from EX
ex_wreg  in  1  GPR write enable from EX
ex_wdata  in  DATA_W  GPR write data from EX
ex_whilo  in  1  HI/LO write enable from EX
ex_hi  in  DATA_W  HI value from EX
ex_lo  in  DATA_W  LO value from EX
hilo_temp_i  in  2*DATA_W  madd/msub partial result from EX
cnt_i  in  2  madd/msub cycle counter from EX
mem_wd_addr  out  ADDR_W  registered destination GPR to MEM
mem_wreg  out  1  registered GPR write enable
mem_wdata  out  DATA_W  registered GPR write data
mem_whilo  out  1  registered HI/LO write enable
mem_hi  out  DATA_W  registered HI
mem_lo  out  DATA_W  registered LO
hilo_temp_o  out  2*DATA_W  held partial result, back to EX
cnt_o  out  2  held counter, back to EX

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- rst low: asynchronous clear, independent of clk. Values:
  - mem_wd_addr=NOP_ADDR
  - mem_wreg=0, mem_whilo=0
  - mem_wdata=0, mem_hi=0, mem_lo=0
  - hilo_temp_o=0, cnt_o=0
- The clear holds for as long as rst is low. The first capture happens on the first rising edge after rst rises.
- Each rising edge with rst high evaluates four cases in priority order. Exactly one applies.
  - 1 flush=1: all outputs go to reset values, including hilo_temp_o/cnt_o. An in-flight madd/msub is aborted. flush overrides any stall.
  - 2 stall[3]=1 and stall[4]=0 (bubble): the six mem_* outputs go to reset values. hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so the accumulator advances while EX is stalled.
  - 3 stall[3]=0 (capture): every mem_* output takes its ex_* input. hilo_temp_o<=0 and cnt_o<=0; the multicycle op has completed.
  - 4 otherwise (stall[3]=1 and stall[4]=1, hold): every output keeps its value, including the accumulator.
- stall[3]=0 with stall[4]=1 is illegal, because ctrl stalls stages contiguously. The block treats it as capture (case 3). The bench flags it as an assertion.
- Latency: exactly 1 cycle EX->MEM on capture. A held value persists for an unbounded number of cycles.
- mem_hi/mem_lo/mem_wdata are captured even when the matching enables are 0. Only the enables are semantically significant.
- No arithmetic is performed. Widths pass through unchanged, and cnt has no wrap logic (EX owns counting).

Test Plan:
- Reset: assert rst=0 mid-cycle with non-zero outputs -> all outputs 0 and mem_wd_addr=0 immediately, without waiting for a clk edge; they stay 0 until the first edge after rst=1.
- Capture: stall=0, ex_wd_addr=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, ex_whilo=1, ex_hi=32'hAAAA_0000, ex_lo=32'h0000_5555 -> the next edge shows the same values on mem_*, with hilo_temp_o=0 and cnt_o=0.
- Madd bubble: stall=6'b001111, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=2'b01 ->
  - mem_wreg=0, mem_whilo=0, mem_wd_addr=0
  - hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1
  - Next edge with stall=0 and ex_wdata=32'h0000_0009: mem_wdata=9, cnt_o=0.
- Hold: capture 32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles while the inputs change -> all outputs stay at their captured values, including the accumulator.
- Flush mid-madd: cnt_o=1 and hilo_temp_o non-zero; drive flush=1 together with stall=6'b001111 -> the next edge has every output 0 (flush wins).
- Back-to-back captures: 4 consecutive edges with stall=0 and ex_wdata=1,2,3,4 -> mem_wdata shows 1,2,3,4, each one cycle later, with no drops or duplicates.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS32 core.
// Carries GPR and HI/LO write-back info from EX to MEM, and holds the
// madd/msub accumulator (partial product plus cycle counter) for EX.
module ex_mem_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NOP_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     ex_wd_addr,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   hilo_temp_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_wd_addr,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [1:0]            cnt_o
);

  localparam logic [ADDR_W-1:0] NOP = ADDR_W'(NOP_ADDR);

  // Only the EX and MEM stall bits matter at this boundary.
  logic stall_unused;
  assign stall_unused = ^{stall[5], stall[2:0]};

  logic                ex_stall;
  logic                mem_stall;
  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];

  logic [ADDR_W-1:0]   wd_addr_nxt;
  logic                wreg_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                whilo_nxt;
  logic [DATA_W-1:0]   hi_nxt;
  logic [DATA_W-1:0]   lo_nxt;
  logic [2*DATA_W-1:0] hilo_temp_nxt;
  logic [1:0]          cnt_nxt;

  // Next-state selection: flush > bubble > capture > hold.
  always_comb begin
    wd_addr_nxt   = mem_wd_addr;
    wreg_nxt      = mem_wreg;
    wdata_nxt     = mem_wdata;
    whilo_nxt     = mem_whilo;
    hi_nxt        = mem_hi;
    lo_nxt        = mem_lo;
    hilo_temp_nxt = hilo_temp_o;
    cnt_nxt       = cnt_o;
    if (flush) begin
      // Abort everything, including an in-flight madd/msub.
      wd_addr_nxt   = NOP;
      wreg_nxt      = 1'b0;
      wdata_nxt     = '0;
      whilo_nxt     = 1'b0;
      hi_nxt        = '0;
      lo_nxt        = '0;
      hilo_temp_nxt = '0;
      cnt_nxt       = 2'd0;
    end else if (ex_stall && !mem_stall) begin
      // Bubble into MEM while the accumulator keeps advancing.
      wd_addr_nxt   = NOP;
      wreg_nxt      = 1'b0;
      wdata_nxt     = '0;
      whilo_nxt     = 1'b0;
      hi_nxt        = '0;
      lo_nxt        = '0;
      hilo_temp_nxt = hilo_temp_i;
      cnt_nxt       = cnt_i;
    end else if (!ex_stall) begin
      // Normal capture; any multicycle op has finished.
      wd_addr_nxt   = ex_wd_addr;
      wreg_nxt      = ex_wreg;
      wdata_nxt     = ex_wdata;
      whilo_nxt     = ex_whilo;
      hi_nxt        = ex_hi;
      lo_nxt        = ex_lo;
      hilo_temp_nxt = '0;
      cnt_nxt       = 2'd0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd_addr <= NOP;
      mem_wreg    <= 1'b0;
      mem_wdata   <= '0;
      mem_whilo   <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      hilo_temp_o <= '0;
      cnt_o       <= 2'd0;
    end else begin
      mem_wd_addr <= wd_addr_nxt;
      mem_wreg    <= wreg_nxt;
      mem_wdata   <= wdata_nxt;
      mem_whilo   <= whilo_nxt;
      mem_hi      <= hi_nxt;
      mem_lo      <= lo_nxt;
      hilo_temp_o <= hilo_temp_nxt;
      cnt_o       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes model predictions,
// a monitor pops and compares one prediction per rising edge.
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  wd_addr;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } out_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd_addr;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } in_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [4:0]  ex_wd_addr = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [63:0] hilo_temp_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [4:0]  mem_wd_addr;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int   tests = 0;
  int   fails = 0;
  out_t model = '0;
  out_t exp_q[$];

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd_addr(ex_wd_addr), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd_addr(mem_wd_addr), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return '{mem_wd_addr, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             hilo_temp_o, cnt_o};
  endfunction

  // Reference behaviour: what the stage should hold after one edge.
  function automatic out_t predict(out_t cur, in_t i, logic rst_v);
    out_t bubble;
    out_t capt;
    bubble = '0;
    bubble.temp = i.temp;
    bubble.cnt  = i.cnt;
    capt = '{i.wd_addr, i.wreg, i.wdata, i.whilo, i.hi, i.lo, 64'd0, 2'd0};
    if (!rst_v || i.flush)             return '0;
    if (i.stall[3] && !i.stall[4])     return bubble;
    if (!i.stall[3])                   return capt;
    return cur;
  endfunction

  function automatic in_t rand_in(logic [5:0] st, logic fl);
    in_t r;
    r.stall   = st;
    r.flush   = fl;
    r.wd_addr = 5'($urandom);
    r.wreg    = 1'($urandom);
    r.wdata   = $urandom;
    r.whilo   = 1'($urandom);
    r.hi      = $urandom;
    r.lo      = $urandom;
    r.temp    = {$urandom, $urandom};
    r.cnt     = 2'($urandom);
    return r;
  endfunction

  // Drive one cycle of inputs and queue the expected post-edge state.
  task automatic step(input in_t i, input logic rst_v);
    @(negedge clk);
    rst = rst_v;
    stall = i.stall; flush = i.flush;
    ex_wd_addr = i.wd_addr; ex_wreg = i.wreg; ex_wdata = i.wdata;
    ex_whilo = i.whilo; ex_hi = i.hi; ex_lo = i.lo;
    hilo_temp_i = i.temp; cnt_i = i.cnt;
    model = predict(model, i, rst_v);
    exp_q.push_back(model);
  endtask

  // Monitor: one comparison per edge once predictions are queued.
  always @(posedge clk) begin
    out_t e;
    out_t g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = dut_out();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL edge_check t=%0t got=%h exp=%h", $time, g, e);
      end
    end
  end

  // Contiguous stall patterns only; EX run with MEM stalled is illegal.
  always @(posedge clk) begin
    if (rst) assert (!(!stall[3] && stall[4]))
      else $error("illegal stall vector %b", stall);
  end

  logic [5:0] legal_st [6] = '{6'b000000, 6'b000011, 6'b000111,
                               6'b001111, 6'b011111, 6'b111111};

  initial begin
    in_t i;
    out_t g;
    // Reset held across an edge.
    i = rand_in(6'b0, 1'b0);
    step(i, 1'b0);
    step(i, 1'b0);

    // Capture.
    i = '{6'b0, 1'b0, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'hAAAA_0000,
          32'h0000_5555, 64'h0, 2'd0};
    step(i, 1'b1);

    // Madd bubble then completion.
    i = rand_in(6'b001111, 1'b0);
    i.temp = 64'h0000_0001_0000_0002; i.cnt = 2'b01;
    step(i, 1'b1);
    i = rand_in(6'b000000, 1'b0);
    i.wdata = 32'h0000_0009;
    step(i, 1'b1);

    // Hold after a capture, and hold with a live accumulator.
    i = rand_in(6'b000000, 1'b0);
    i.wdata = 32'hDEAD_BEEF;
    step(i, 1'b1);
    for (int k = 0; k < 3; k++) step(rand_in(6'b011111, 1'b0), 1'b1);
    i = rand_in(6'b001111, 1'b0);
    i.cnt = 2'b01; i.temp = 64'hCAFE_0000_1234_0001;
    step(i, 1'b1);
    for (int k = 0; k < 3; k++) step(rand_in(6'b111111, 1'b0), 1'b1);

    // Flush mid-madd wins over stall.
    step(rand_in(6'b001111, 1'b1), 1'b1);

    // Back-to-back captures.
    for (int k = 1; k <= 4; k++) begin
      i = rand_in(6'b0, 1'b0);
      i.wdata = 32'(k);
      step(i, 1'b1);
    end

    // Asynchronous reset mid-cycle with non-zero outputs.
    i = rand_in(6'b0, 1'b0);
    i.wreg = 1'b1; i.wd_addr = 5'd17; i.wdata = 32'h5A5A_5A5A;
    step(i, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    g = dut_out();
    tests++;
    if (g !== '0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=0", g);
    end
    model = '0;
    step(rand_in(6'b0, 1'b0), 1'b0);
    step(rand_in(6'b0, 1'b0), 1'b1);

    // Randomised legal traffic.
    for (int k = 0; k < 400; k++) begin
      logic [5:0] st;
      st = legal_st[$urandom_range(0, 5)];
      step(rand_in(st, ($urandom_range(0, 15) == 0)), 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
